// File: rtl/ac_tone_gen.sv
// Dual-channel test-tone generator feeding the codec DAC sink: one L/R sample pair per request,
// both channels time-sharing a single waveform unit under a four-state sequencer.
module ac_tone_gen #(
    parameter int DATA_WDT  = 24,
    parameter int PHASE_WDT = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dacReq,
    input  logic                    cfgEn,
    input  logic [1:0]              cfgSrcL,
    input  logic [1:0]              cfgSrcR,
    input  logic [15:0]             cfgFrqL,
    input  logic [15:0]             cfgFrqR,
    input  logic                    clrOvr,
    output logic [2*DATA_WDT-1:0]   dacData,
    output logic                    dacValid,
    output logic                    busy,
    output logic                    ovr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LATCH  = 2'd1,
        WAVE_L = 2'd2,
        WAVE_R = 2'd3
    } state_t;

    localparam logic [1:0] SRC_OFF = 2'd0;
    localparam logic [1:0] SRC_SAW = 2'd1;
    localparam logic [1:0] SRC_SQR = 2'd2;

    state_t                      state_q, state_d;
    logic                        en_q, en_d;
    logic [1:0]                  src_l_q, src_l_d, src_r_q, src_r_d;
    logic [15:0]                 frq_l_q, frq_l_d, frq_r_q, frq_r_d;
    logic [PHASE_WDT-1:0]        phase_l_q, phase_l_d, phase_r_q, phase_r_d;
    logic signed [DATA_WDT-1:0]  samp_l_q, samp_l_d;
    logic [2*DATA_WDT-1:0]       data_q, data_d;
    logic                        valid_q, valid_d;
    logic                        ovr_q, ovr_d;

    logic [1:0]                  wave_src;
    logic [15:0]                 wave_u;
    logic signed [DATA_WDT-1:0]  wave_s;

    function automatic logic [15:0] wave_fn(input logic [1:0] src, input logic [15:0] u);
        logic [15:0] t;
        t = {u[14:0], 1'b0};
        if (u[15]) t = ~t;
        case (src)
            SRC_OFF: return 16'h0000;
            SRC_SAW: return u ^ 16'h8000;
            SRC_SQR: return u[15] ? 16'h8001 : 16'h7FFF;
            default: return t ^ 16'h8000;
        endcase
    endfunction

    // Left-justify the 16-bit waveform into the sample word, low bits zero.
    function automatic logic signed [DATA_WDT-1:0] justify(input logic [15:0] r);
        return signed'(DATA_WDT'(r) << (DATA_WDT - 16));
    endfunction

    always_comb begin
        wave_src = (state_q == WAVE_R) ? src_r_q : src_l_q;
        wave_u   = (state_q == WAVE_R) ? phase_r_q[PHASE_WDT-1 -: 16]
                                       : phase_l_q[PHASE_WDT-1 -: 16];
        wave_s   = en_q ? justify(wave_fn(wave_src, wave_u)) : '0;
    end

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        src_l_d   = src_l_q;
        src_r_d   = src_r_q;
        frq_l_d   = frq_l_q;
        frq_r_d   = frq_r_q;
        phase_l_d = phase_l_q;
        phase_r_d = phase_r_q;
        samp_l_d  = samp_l_q;
        data_d    = data_q;
        valid_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (dacReq) state_d = LATCH;
            end
            LATCH: begin
                en_d    = cfgEn;
                src_l_d = cfgSrcL;
                src_r_d = cfgSrcR;
                frq_l_d = cfgFrqL;
                frq_r_d = cfgFrqR;
                state_d = WAVE_L;
            end
            WAVE_L: begin
                samp_l_d  = wave_s;
                phase_l_d = en_q ? phase_l_q + PHASE_WDT'(frq_l_q) : '0;
                state_d   = WAVE_R;
            end
            default: begin
                data_d    = {samp_l_q, wave_s};
                valid_d   = 1'b1;
                phase_r_d = en_q ? phase_r_q + PHASE_WDT'(frq_r_q) : '0;
                state_d   = IDLE;
            end
        endcase

        // A request arriving mid-sequence is dropped; setting beats clearing.
        ovr_d = ovr_q;
        if (dacReq && (state_q != IDLE)) ovr_d = 1'b1;
        else if (clrOvr)                 ovr_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            src_l_q   <= '0;
            src_r_q   <= '0;
            frq_l_q   <= '0;
            frq_r_q   <= '0;
            phase_l_q <= '0;
            phase_r_q <= '0;
            samp_l_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            src_l_q   <= src_l_d;
            src_r_q   <= src_r_d;
            frq_l_q   <= frq_l_d;
            frq_r_q   <= frq_r_d;
            phase_l_q <= phase_l_d;
            phase_r_q <= phase_r_d;
            samp_l_q  <= samp_l_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    assign dacData  = data_q;
    assign dacValid = valid_q;
    assign busy     = (state_q != IDLE);
    assign ovr      = ovr_q;

endmodule

// File: tb/tb_ac_tone_gen.sv
// Bench for ac_tone_gen: a 16/16 and a 24/24 instance share stimulus and are checked
// against a per-request phase/waveform model.
module tb_ac_tone_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, dacReq, cfgEn, clrOvr;
    logic [1:0]  cfgSrcL, cfgSrcR;
    logic [15:0] cfgFrqL, cfgFrqR;
    logic [31:0] d16;
    logic [47:0] d24;
    logic        v16, b16, o16, v24, b24, o24;

    ac_tone_gen #(.DATA_WDT(16), .PHASE_WDT(16)) dut16 (
        .clk(clk), .reset(reset), .dacReq(dacReq), .cfgEn(cfgEn),
        .cfgSrcL(cfgSrcL), .cfgSrcR(cfgSrcR), .cfgFrqL(cfgFrqL), .cfgFrqR(cfgFrqR),
        .clrOvr(clrOvr), .dacData(d16), .dacValid(v16), .busy(b16), .ovr(o16));

    ac_tone_gen #(.DATA_WDT(24), .PHASE_WDT(24)) dut24 (
        .clk(clk), .reset(reset), .dacReq(dacReq), .cfgEn(cfgEn),
        .cfgSrcL(cfgSrcL), .cfgSrcR(cfgSrcR), .cfgFrqL(cfgFrqL), .cfgFrqR(cfgFrqR),
        .clrOvr(clrOvr), .dacData(d24), .dacValid(v24), .busy(b24), .ovr(o24));

    int total = 0;
    int bad   = 0;

    // Model phase per instance (0: 16/16, 1: 24/24) and per channel (0: L, 1: R).
    longint unsigned ph[2][2];
    int              pw[2] = '{16, 24};
    int              dw[2] = '{16, 24};
    logic [63:0]     exp16, exp24;
    int              nv;

    logic [15:0] t1L[4] = '{16'h8000, 16'hC000, 16'h0000, 16'h4000};
    logic [15:0] t1R[4] = '{16'h8000, 16'h9000, 16'hA000, 16'hB000};
    logic [15:0] t2L[4] = '{16'h8000, 16'h0000, 16'h7FFF, 16'hFFFF};
    logic [15:0] t2R[4] = '{16'h7FFF, 16'h7FFF, 16'h8001, 16'h8001};

    function automatic longint unsigned wave(int src, longint unsigned u);
        longint unsigned t;
        case (src)
            0: return 0;
            1: return u ^ 'h8000;
            2: return (u < 'h8000) ? 'h7FFF : 'h8001;
            default: begin
                t = (2 * u) % 65536;
                if (u >= 'h8000) t = 65535 - t;
                return t ^ 'h8000;
            end
        endcase
    endfunction

    function automatic logic [63:0] model_step(int d);
        longint unsigned s[2];
        longint unsigned u, frq;
        int src;
        for (int ch = 0; ch < 2; ch++) begin
            src = (ch == 0) ? int'(cfgSrcL) : int'(cfgSrcR);
            frq = (ch == 0) ? longint'(cfgFrqL) : longint'(cfgFrqR);
            u   = ph[d][ch] >> (pw[d] - 16);
            s[ch] = cfgEn ? (wave(src, u) << (dw[d] - 16)) : 0;
            ph[d][ch] = cfgEn ? (ph[d][ch] + frq) % (64'd1 << pw[d]) : 0;
        end
        return (s[0] << dw[d]) | s[1];
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < 2; ch++) ph[d][ch] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        model_reset();
        reset = 1'b1;
        tick();
    endtask

    // One accepted request; optionally alters cfgFrqL after the capture edge.
    task automatic req(string tag, bit mut, logic [15:0] nf);
        dacReq = 1'b1;
        tick();                              // edge N
        dacReq = 1'b0;
        exp16 = model_step(0);
        exp24 = model_step(1);
        chk({tag, "_busyN"}, {b16, b24}, 2'b11);
        chk({tag, "_vldN"}, {v16, v24}, 2'b00);
        tick();                              // N+1
        if (mut) cfgFrqL = nf;
        chk({tag, "_vldN1"}, {v16, v24}, 2'b00);
        tick();                              // N+2
        chk({tag, "_vldN2"}, {v16, v24}, 2'b00);
        tick();                              // N+3
        chk({tag, "_vldN3"}, {v16, v24}, 2'b11);
        chk({tag, "_idleN3"}, {b16, b24}, 2'b00);
        chk({tag, "_d16"}, d16, exp16);
        chk({tag, "_d24"}, d24, exp24);
        tick();                              // N+4
        chk({tag, "_vldN4"}, {v16, v24}, 2'b00);
        chk({tag, "_hold16"}, d16, exp16);
    endtask

    initial begin
        reset = 1'b0; dacReq = 1'b0; cfgEn = 1'b1; clrOvr = 1'b0;
        cfgSrcL = 2'd1; cfgSrcR = 2'd1; cfgFrqL = 16'h4000; cfgFrqR = 16'h1000;
        model_reset();
        tick();
        chk("rst_out16", {d16, v16, b16, o16}, '0);
        chk("rst_out24", {d24, v24, b24, o24}, '0);
        reset = 1'b1;
        tick();

        // Latency and saw
        for (int i = 0; i < 4; i++) begin
            req("t1", 1'b0, 16'h0);
            chk("t1_L", d16[31:16], t1L[i]);
            chk("t1_R", d16[15:0], t1R[i]);
            tick(); tick(); tick();
        end

        // Triangle and square
        do_reset();
        cfgSrcL = 2'd3; cfgSrcR = 2'd2; cfgFrqL = 16'h4000; cfgFrqR = 16'h4000;
        for (int i = 0; i < 4; i++) begin
            req("t2", 1'b0, 16'h0);
            chk("t2_L", d16[31:16], t2L[i]);
            chk("t2_R", d16[15:0], t2R[i]);
        end

        // Width and wrap with randomized right channel
        do_reset();
        cfgSrcL = 2'd1; cfgFrqL = 16'hFFFF;
        for (int i = 0; i < 257; i++) begin
            cfgSrcR = 2'($urandom_range(3));
            cfgFrqR = 16'($urandom);
            req("t3", 1'b0, 16'h0);
            chk("t3_lowbits", {d24[31:24], d24[7:0]}, 16'h0000);
        end

        // Overrun: second request dropped, sticky until cleared
        do_reset();
        cfgSrcL = 2'd1; cfgSrcR = 2'd3; cfgFrqL = 16'h2345; cfgFrqR = 16'h0F0F;
        chk("t4_ovr0", {o16, o24}, 2'b00);
        dacReq = 1'b1;
        tick();                              // N
        dacReq = 1'b0;
        exp16 = model_step(0);
        exp24 = model_step(1);
        tick();                              // N+1
        dacReq = 1'b1;
        tick();                              // N+2
        dacReq = 1'b0;
        nv = 0;
        for (int i = 3; i < 10; i++) begin
            tick();                          // N+3 .. N+9
            if (v16) nv++;
            if (i == 3) begin
                chk("t4_ovrN3", {o16, o24}, 2'b11);
                chk("t4_d16", d16, exp16);
                chk("t4_d24", d24, exp24);
            end
        end
        chk("t4_nvalid", 64'(nv), 64'd1);
        chk("t4_ovr_sticky", {o16, o24}, 2'b11);
        clrOvr = 1'b1;
        tick();                              // N+10
        clrOvr = 1'b0;
        chk("t4_ovr_clr", {o16, o24}, 2'b00);
        dacReq = 1'b1;
        tick();                              // M
        exp16 = model_step(0);
        exp24 = model_step(1);
        clrOvr = 1'b1;
        tick();                              // M+1: clear and overrun together
        dacReq = 1'b0; clrOvr = 1'b0;
        chk("t4_set_wins", {o16, o24}, 2'b11);
        tick(); tick();                      // M+3
        chk("t4b_vld", {v16, v24}, 2'b11);
        chk("t4b_d16", d16, exp16);
        chk("t4b_d24", d24, exp24);
        tick();

        // Enable and capture
        do_reset();
        cfgEn = 1'b0; cfgSrcL = 2'd1; cfgSrcR = 2'd1; cfgFrqL = 16'h1000; cfgFrqR = 16'h0800;
        req("t5_off0", 1'b0, 16'h0);
        chk("t5_zero", d16, 32'h0);
        req("t5_off1", 1'b0, 16'h0);
        cfgEn = 1'b1;
        req("t5_on", 1'b0, 16'h0);
        chk("t5_ph0", d16, 32'h8000_8000);
        req("t5_cap", 1'b1, 16'h3000);
        chk("t5_old_frq", d16[31:16], 16'h9000);
        req("t5_new", 1'b0, 16'h0);
        chk("t5_new_frq", d16[31:16], 16'hA000);

        // Reset mid-operation
        cfgSrcL = 2'd2; cfgSrcR = 2'd1; cfgFrqL = 16'h9000; cfgFrqR = 16'h4321;
        req("t6_pre", 1'b0, 16'h0);
        dacReq = 1'b1;
        tick();                              // N
        dacReq = 1'b0;
        tick();                              // N+1
        reset = 1'b0;
        #1;
        chk("t6_rst16", {d16, v16, b16, o16}, '0);
        chk("t6_rst24", {d24, v24, b24, o24}, '0);
        tick();
        reset = 1'b1;
        model_reset();
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (v16 || v24) nv++;
        end
        chk("t6_no_valid", 64'(nv), 64'd0);
        req("t6_post", 1'b0, 16'h0);
        chk("t6_ph0", d16, 32'h7FFF_8000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
